// File: rtl/hub75_row_scanner_pkg.sv
// hub75_row_scanner_pkg
//   Shared definitions for the HUB75 row scanner:
//   - scan_state_t : FSM state encoding
//   - idx_width()  : width of a row/plane index for a given count
//   - plane_onehot(): one-hot bit-plane mask for plane k
package hub75_row_scanner_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_PRIME,
    S_BLANK,
    S_LATCH,
    S_DISPLAY
  } scan_state_t;

  localparam int unsigned MAX_PLANES = 16;

  function automatic int unsigned idx_width(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  function automatic logic [MAX_PLANES-1:0] plane_onehot(input int unsigned k);
    return MAX_PLANES'(1) << k;
  endfunction

endpackage

// File: rtl/hub75_scan_index.sv
// hub75_scan_index
//   (row, plane) position counter. Plane is the inner loop, row the outer;
//   both wrap to 0. Exposes the next position combinationally so callers can
//   act on it in the same cycle they advance.
// Ports
//   clk_25MHz  in  clock
//   rst_n      in  synchronous active-low reset
//   clr        in  return to (0,0)
//   adv        in  step to the next position
//   row/plane  out current position
//   nxt_row/nxt_plane out position after the next advance
//   last       out current position is the last of the frame
module hub75_scan_index
  import hub75_row_scanner_pkg::*;
#(
  parameter  int unsigned NUM_ROWS = 32,
  parameter  int unsigned PWM_BITS = 7,
  localparam int unsigned ROW_W    = idx_width(NUM_ROWS),
  localparam int unsigned PLANE_W  = idx_width(PWM_BITS)
) (
  input  logic               clk_25MHz,
  input  logic               rst_n,
  input  logic               clr,
  input  logic               adv,
  output logic [ROW_W-1:0]   row,
  output logic [PLANE_W-1:0] plane,
  output logic [ROW_W-1:0]   nxt_row,
  output logic [PLANE_W-1:0] nxt_plane,
  output logic               last
);

  logic plane_wrap;
  logic row_wrap;

  always_comb begin
    plane_wrap = (plane == PLANE_W'(PWM_BITS - 1));
    row_wrap   = (row == ROW_W'(NUM_ROWS - 1));
    last       = plane_wrap && row_wrap;
    nxt_plane  = plane_wrap ? '0 : plane + 1'b1;
    nxt_row    = plane_wrap ? (row_wrap ? '0 : row + 1'b1) : row;
  end

  always_ff @(posedge clk_25MHz) begin
    if (!rst_n || clr) begin
      row   <= '0;
      plane <= '0;
    end else if (adv) begin
      row   <= nxt_row;
      plane <= nxt_plane;
    end
  end

endmodule

// File: rtl/hub75_row_scanner.sv
// hub75_row_scanner
//   Drives a line renderer (render_begin/render_done handshake) and the HUB75
//   panel controls for binary-coded PWM. The next (row, plane) is shifted while
//   the current one is displayed.
//   Optional build macro HUB75_GLOBAL_DIM_EN adds dim[1:0], which divides every
//   on-time by 2**dim (minimum 1 cycle), sampled when the latch ends.
// Ports
//   clk_25MHz    in  clock
//   rst_n        in  synchronous active-low reset
//   enable       in  run scanning while high
//   dim          in  global dimming shift (HUB75_GLOBAL_DIM_EN only)
//   render_begin out 1-cycle pulse: start shifting render_addr/pwm
//   render_done  in  renderer finished (level)
//   render_addr  out row being shifted
//   pwm          out one-hot plane being shifted
//   addr         out panel row address being displayed
//   lat          out panel latch
//   oe_n         out panel output enable, active low
//   frame_done   out 1-cycle pulse at the latch of the last (row, plane)
//
// state   | meaning
// IDLE    | dark, waiting for enable; issues the first shift
// PRIME   | waiting for the first shift of a run to finish
// BLANK   | dark before the latch, panel address updated
// LATCH   | lat high; on exit start display timer and next shift
// DISPLAY | lit while timer runs, then dark until the shift finishes
module hub75_row_scanner
  import hub75_row_scanner_pkg::*;
#(
  parameter  int unsigned NUM_ROWS       = 32,
  parameter  int unsigned PWM_BITS       = 7,
  parameter  int unsigned BASE_ON_CYCLES = 8,
  parameter  int unsigned BLANK_CYCLES   = 2,
  parameter  int unsigned LAT_CYCLES     = 1,
  localparam int unsigned ROW_W          = idx_width(NUM_ROWS)
) (
  input  logic                clk_25MHz,
  input  logic                rst_n,
  input  logic                enable,
`ifdef HUB75_GLOBAL_DIM_EN
  input  logic [1:0]          dim,
`endif
  output logic                render_begin,
  input  logic                render_done,
  output logic [ROW_W-1:0]    render_addr,
  output logic [PWM_BITS-1:0] pwm,
  output logic [ROW_W-1:0]    addr,
  output logic                lat,
  output logic                oe_n,
  output logic                frame_done
);

  localparam int unsigned PLANE_W = idx_width(PWM_BITS);
  localparam int unsigned CNT_W   = $clog2(BASE_ON_CYCLES << (PWM_BITS - 1)) + 1;
  localparam int unsigned PH_MAX  = (BLANK_CYCLES > LAT_CYCLES) ? BLANK_CYCLES : LAT_CYCLES;
  localparam int unsigned PH_W    = $clog2(PH_MAX) + 1;

  scan_state_t        state;
  logic [PH_W-1:0]    phase_cnt;
  logic [CNT_W-1:0]   disp_cnt;
  logic [CNT_W-1:0]   on_full;
  logic [CNT_W-1:0]   on_load;

  logic [ROW_W-1:0]   sh_row, sh_nxt_row, dp_row, dp_nxt_row;
  logic [PLANE_W-1:0] sh_plane, sh_nxt_plane, dp_plane, dp_nxt_plane;
  logic               sh_last, dp_last;
  logic               done_ok, latch_end, disp_end;
  logic               sh_adv, dp_adv, idx_clr;
  logic               unused_idx;

  // The renderer may still show the previous shift's done in the cycle right
  // after a begin, so done is only trusted when begin is not being presented.
  always_comb begin
    done_ok   = render_done && !render_begin;
    latch_end = (state == S_LATCH) && (phase_cnt == '0);
    disp_end  = (state == S_DISPLAY) && (disp_cnt == '0) && done_ok;
    sh_adv    = latch_end;
    dp_adv    = disp_end && enable;
    idx_clr   = disp_end && !enable;
  end

  always_comb begin
    on_full = CNT_W'(BASE_ON_CYCLES) << dp_plane;
`ifdef HUB75_GLOBAL_DIM_EN
    on_load = on_full >> dim;
    if (on_load == '0) on_load = CNT_W'(1);
`else
    on_load = on_full;
`endif
  end

  // Shift index: position being (or just) shifted into the panel.
  hub75_scan_index #(.NUM_ROWS(NUM_ROWS), .PWM_BITS(PWM_BITS)) u_shift_idx (
    .clk_25MHz (clk_25MHz),
    .rst_n     (rst_n),
    .clr       (idx_clr),
    .adv       (sh_adv),
    .row       (sh_row),
    .plane     (sh_plane),
    .nxt_row   (sh_nxt_row),
    .nxt_plane (sh_nxt_plane),
    .last      (sh_last)
  );

  // Display index: position latched and shown; sets on-time and frame_done.
  hub75_scan_index #(.NUM_ROWS(NUM_ROWS), .PWM_BITS(PWM_BITS)) u_disp_idx (
    .clk_25MHz (clk_25MHz),
    .rst_n     (rst_n),
    .clr       (idx_clr),
    .adv       (dp_adv),
    .row       (dp_row),
    .plane     (dp_plane),
    .nxt_row   (dp_nxt_row),
    .nxt_plane (dp_nxt_plane),
    .last      (dp_last)
  );

  assign unused_idx = ^{sh_last, dp_row, dp_nxt_row, dp_nxt_plane};

  always_ff @(posedge clk_25MHz) begin
    if (!rst_n) begin
      state        <= S_IDLE;
      phase_cnt    <= '0;
      disp_cnt     <= '0;
      render_begin <= 1'b0;
      render_addr  <= '0;
      pwm          <= PWM_BITS'(1);
      addr         <= '0;
      lat          <= 1'b0;
      oe_n         <= 1'b1;
      frame_done   <= 1'b0;
    end else begin
      render_begin <= 1'b0;
      frame_done   <= 1'b0;
      case (state)
        S_IDLE: begin
          oe_n <= 1'b1;
          lat  <= 1'b0;
          if (enable) begin
            render_begin <= 1'b1;
            render_addr  <= sh_row;
            pwm          <= PWM_BITS'(plane_onehot(32'(sh_plane)));
            state        <= S_PRIME;
          end
        end
        S_PRIME: begin
          if (done_ok) begin
            addr      <= sh_row;
            phase_cnt <= PH_W'(BLANK_CYCLES - 1);
            state     <= S_BLANK;
          end
        end
        S_BLANK: begin
          oe_n <= 1'b1;
          if (phase_cnt == '0) begin
            lat        <= 1'b1;
            frame_done <= dp_last;
            phase_cnt  <= PH_W'(LAT_CYCLES - 1);
            state      <= S_LATCH;
          end else begin
            phase_cnt <= phase_cnt - 1'b1;
          end
        end
        S_LATCH: begin
          if (phase_cnt == '0) begin
            lat          <= 1'b0;
            oe_n         <= 1'b0;
            disp_cnt     <= on_load;
            render_begin <= 1'b1;
            render_addr  <= sh_nxt_row;
            pwm          <= PWM_BITS'(plane_onehot(32'(sh_nxt_plane)));
            state        <= S_DISPLAY;
          end else begin
            phase_cnt <= phase_cnt - 1'b1;
          end
        end
        S_DISPLAY: begin
          if (disp_cnt != '0) begin
            disp_cnt <= disp_cnt - 1'b1;
            oe_n     <= (disp_cnt == CNT_W'(1));
          end else if (done_ok) begin
            if (enable) begin
              addr      <= sh_row;
              phase_cnt <= PH_W'(BLANK_CYCLES - 1);
              state     <= S_BLANK;
            end else begin
              state <= S_IDLE;
            end
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_hub75_row_scanner.sv
// tb_hub75_row_scanner
//   Directed bench for hub75_row_scanner with a small panel
//   (2 rows, 2 planes, base on-time 4, blank 2, latch 1). A renderer model
//   raises render_done a programmable number of cycles after each begin.
//   Build with HUB75_GLOBAL_DIM_EN to exercise the dim input.
module tb_hub75_row_scanner;

  logic       clk_25MHz = 1'b0;
  logic       rst_n     = 1'b0;
  logic       enable    = 1'b0;
  logic       render_done = 1'b1;
  logic       render_begin;
  logic [0:0] render_addr;
  logic [1:0] pwm;
  logic [0:0] addr;
  logic       lat;
  logic       oe_n;
  logic       frame_done;
`ifdef HUB75_GLOBAL_DIM_EN
  logic [1:0] dim = 2'd0;
`endif

  int n_assert = 0;
  int n_fail   = 0;
  int delay    = 10;
  int rcnt     = 0;

  int begin_cnt = 0, lat_cnt = 0, low_total = 0, run = 0, hi = 0;
  int runs[$], gaps[$], addrs[$], fd_lat[$];
  logic lat_q = 1'b0;

  hub75_row_scanner #(
    .NUM_ROWS(2), .PWM_BITS(2), .BASE_ON_CYCLES(4), .BLANK_CYCLES(2), .LAT_CYCLES(1)
  ) dut (
    .clk_25MHz    (clk_25MHz),
    .rst_n        (rst_n),
    .enable       (enable),
`ifdef HUB75_GLOBAL_DIM_EN
    .dim          (dim),
`endif
    .render_begin (render_begin),
    .render_done  (render_done),
    .render_addr  (render_addr),
    .pwm          (pwm),
    .addr         (addr),
    .lat          (lat),
    .oe_n         (oe_n),
    .frame_done   (frame_done)
  );

  always #20 clk_25MHz = ~clk_25MHz;

  // Renderer: drops done when it sees begin, raises it `delay` cycles later.
  always @(negedge clk_25MHz) begin
    if (render_begin === 1'b1) begin
      render_done = 1'b0;
      rcnt = delay;
    end else if (rcnt > 0) begin
      rcnt--;
      if (rcnt == 0) render_done = 1'b1;
    end
  end

  // Observer: oe_n low runs, high gaps before each run, addr at run start,
  // latch and begin counts, latch number at each frame_done.
  always @(negedge clk_25MHz) begin
    if (render_begin === 1'b1) begin_cnt++;
    if (lat === 1'b1 && lat_q !== 1'b1) lat_cnt++;
    if (frame_done === 1'b1) fd_lat.push_back(lat_cnt);
    lat_q = lat;
    if (oe_n === 1'b0) begin
      if (run == 0) begin
        gaps.push_back(hi);
        addrs.push_back(int'(addr));
        hi = 0;
      end
      run++;
      low_total++;
    end else begin
      if (run > 0) begin
        runs.push_back(run);
        run = 0;
      end
      hi++;
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) begin
      @(negedge clk_25MHz);
      #1;
    end
  endtask

  task automatic wait_lat_edge(input string tag, input int budget);
    int start = lat_cnt;
    int n = 0;
    while (lat_cnt == start && n < budget) begin
      step(1);
      n++;
    end
    chk(tag, 32'(lat_cnt != start), 1);
  endtask

  task automatic wait_runs(input string tag, input int target, input int budget);
    int n = 0;
    while (runs.size() < target && n < budget) begin
      step(1);
      n++;
    end
    chk(tag, 32'(runs.size() >= target), 1);
  endtask

  task automatic wait_oe_low(input string tag, input logic [0:0] want_addr,
                             input logic match_addr, input int budget);
    int n = 0;
    while (!(oe_n === 1'b0 && (!match_addr || addr === want_addr)) && n < budget) begin
      step(1);
      n++;
    end
    chk(tag, 32'(oe_n === 1'b0), 1);
  endtask

  initial begin
    int base, l0, p0, r0, exp0, exp1;

    // Reset values
    step(3);
    chk("rst_begin", 32'(render_begin), 0);
    chk("rst_render_addr", 32'(render_addr), 0);
    chk("rst_pwm", 32'(pwm), 1);
    chk("rst_addr", 32'(addr), 0);
    chk("rst_lat", 32'(lat), 0);
    chk("rst_oe_n", 32'(oe_n), 1);
    chk("rst_frame_done", 32'(frame_done), 0);

    // First begin after enable
    rst_n  = 1'b1;
    enable = 1'b1;
    step(1);
    chk("first_begin", 32'(render_begin), 1);
    chk("first_render_addr", 32'(render_addr), 0);
    chk("first_pwm", 32'(pwm), 1);
    chk("first_oe_n", 32'(oe_n), 1);
    step(1);
    chk("begin_one_cycle", 32'(render_begin), 0);

    // Dark until the first latch, one begin so far
    wait_lat_edge("first_lat_timeout", 100);
    chk("dark_before_latch", 32'(low_total), 0);
    chk("begins_at_first_latch", 32'(begin_cnt), 1);
    chk("first_latch_addr", 32'(addr), 0);

    // Steady run, renderer at 10 cycles
    wait_runs("steady_timeout", 8, 1000);
    chk("run0_on", 32'(runs[0]), 4);
    chk("run1_on", 32'(runs[1]), 8);
    chk("run2_on", 32'(runs[2]), 4);
    chk("run3_on", 32'(runs[3]), 8);
    chk("run4_on", 32'(runs[4]), 4);
    chk("run0_addr", 32'(addrs[0]), 0);
    chk("run1_addr", 32'(addrs[1]), 0);
    chk("run2_addr", 32'(addrs[2]), 1);
    chk("run3_addr", 32'(addrs[3]), 1);
    chk("run4_addr_wrap", 32'(addrs[4]), 0);
    // after plane0: dark until done (cycle 11), blank 2, latch 1 -> 10 cycles
    chk("gap1_stall", 32'(gaps[1]), 10);
    chk("gap2_stall", 32'(gaps[2]), 6);
    chk("frame_done_count", 32'(fd_lat.size()), 2);
    chk("frame_done_at_lat4", 32'(fd_lat[0]), 4);
    chk("frame_done_at_lat8", 32'(fd_lat[1]), 8);

    // Renderer slowed to 20 cycles
    wait_lat_edge("slow_align_timeout", 200);
    delay = 20;
    l0   = lat_cnt;
    p0   = (l0 - 1) % 2;
    base = runs.size();
    chk("begins_eq_latches_a", 32'(begin_cnt), 32'(lat_cnt));
    wait_runs("slow_timeout", base + 2, 500);
    chk("slow_run0_on", 32'(runs[base]), 32'(4 << p0));
    chk("slow_run1_on", 32'(runs[base + 1]), 32'(4 << (1 - p0)));
    chk("slow_gap_stall", 32'(gaps[base + 1]), 32'(24 - (4 << p0)));
    wait_lat_edge("slow_lat_timeout", 200);
    chk("begins_eq_latches_b", 32'(begin_cnt), 32'(lat_cnt));

    // Enable dropped during DISPLAY
    wait_lat_edge("drop_align_timeout", 200);
    wait_oe_low("drop_oe_timeout", 1'b0, 1'b0, 50);
    l0 = lat_cnt;
    p0 = (l0 - 1) % 2;
    r0 = runs.size();
    enable = 1'b0;
    step(60);
    chk("drop_no_latch", 32'(lat_cnt), 32'(l0));
    chk("drop_oe_n", 32'(oe_n), 1);
    chk("drop_runs", 32'(runs.size()), 32'(r0 + 1));
    chk("drop_full_on", 32'(runs[r0]), 32'(4 << p0));
    chk("drop_begins", 32'(begin_cnt), 32'(l0 + 1));
    chk("drop_begin_low", 32'(render_begin), 0);

    // Re-enable restarts at (0,0)
    enable = 1'b1;
    step(1);
    chk("restart_begin", 32'(render_begin), 1);
    chk("restart_render_addr", 32'(render_addr), 0);
    chk("restart_pwm", 32'(pwm), 1);
    wait_lat_edge("restart_lat_timeout", 200);
    chk("restart_latch_addr", 32'(addr), 0);
    wait_runs("restart_run_timeout", r0 + 2, 200);
    chk("restart_plane0_on", 32'(runs[r0 + 1]), 4);

    // Reset during DISPLAY of row 1
    wait_oe_low("row1_display_timeout", 1'b1, 1'b1, 400);
    rst_n  = 1'b0;
    enable = 1'b0;
    step(1);
    chk("mid_rst_oe_n", 32'(oe_n), 1);
    chk("mid_rst_lat", 32'(lat), 0);
    chk("mid_rst_addr", 32'(addr), 0);
    chk("mid_rst_begin", 32'(render_begin), 0);
    chk("mid_rst_pwm", 32'(pwm), 1);
    chk("mid_rst_render_addr", 32'(render_addr), 0);

    // Restart after reset; dimmed on-times when the option is built in
`ifdef HUB75_GLOBAL_DIM_EN
    dim  = 2'd2;
    exp0 = 1;
    exp1 = 2;
`else
    exp0 = 4;
    exp1 = 8;
`endif
    base   = runs.size();
    rst_n  = 1'b1;
    enable = 1'b1;
    wait_runs("post_rst_timeout", base + 2, 500);
    chk("post_rst_plane0_on", 32'(runs[base]), 32'(exp0));
    chk("post_rst_plane1_on", 32'(runs[base + 1]), 32'(exp1));

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
